// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Write port that wins both the array update and the read bypass on an address clash.
  localparam int WR_PRIO_PORT = 1;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending bits: tracks registers that have an outstanding producer.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = rf_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic [1:0]        clr_en_i,
  input  logic [2*AW-1:0]   clr_addr_i,
  input  logic              flush_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_pend_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Next pending vector: clears first so a same-register set (younger producer) wins; flush overrides all.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (clr_en_i[p]) begin
          pend_d[clr_addr_i[p*AW +: AW]] = 1'b0;
        end
      end
      if (set_en_i) begin
        pend_d[set_addr_i] = 1'b1;
      end
    end
  end

  // Pending bits register, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Per-port lookup: a write landing this cycle already satisfies the dependency.
  always_comb begin
    rd_pend_o = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_pend_o[i] = pend_q[rd_addr_i[i*AW +: AW]]
                   & ~(clr_en_i[0] && (clr_addr_i[0 +: AW] == rd_addr_i[i*AW +: AW]))
                   & ~(clr_en_i[1] && (clr_addr_i[AW +: AW] == rd_addr_i[i*AW +: AW]));
      if ((ZERO_REG != 0) && (rd_addr_i[i*AW +: AW] == '0)) begin
        rd_pend_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, RAW scoreboard and post-reset zeroing sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_pend_o,
  input  logic [1:0]          we_i,
  input  logic [2*AW-1:0]     wa_i,
  input  logic [2*XLEN-1:0]   wd_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  input  logic                flush_i,
  output logic                init_busy_o
);

  localparam int HI = WR_PRIO_PORT;
  localparam int LO = 1 - WR_PRIO_PORT;

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  mem [NREGS];
  logic             ready;
  logic [1:0]       wr_en;
  logic             sb_set;
  logic [NRD-1:0]   sb_pend;

  assign ready       = (state_q == RF_READY);
  assign init_busy_o = ~ready;

  // Init sequencer: walk every register once, then stay ready until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = RF_READY;
      end
    end
  end

  // Sequencer state and counter; reset restarts the zeroing from register 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accepted writes: only when ready, and never to the hard-wired zero register.
  always_comb begin
    wr_en = '0;
    for (int p = 0; p < 2; p++) begin
      wr_en[p] = ready && we_i[p] &&
                 !((ZERO_REG != 0) && (wa_i[p*AW +: AW] == '0));
    end
  end

  // Storage has no reset so it can map to RAM; the sequencer zeroes it instead, and the priority port writes last.
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr_en[LO]) mem[wa_i[LO*AW +: AW]] <= wd_i[LO*XLEN +: XLEN];
      if (wr_en[HI]) mem[wa_i[HI*AW +: AW]] <= wd_i[HI*XLEN +: XLEN];
    end
  end

  // Combinational read ports with same-cycle bypass from the write ports.
  always_comb begin
    rd_data_o = '0;
    if (ready) begin
      for (int i = 0; i < NRD; i++) begin
        if ((ZERO_REG != 0) && (rd_addr_i[i*AW +: AW] == '0)) begin
          rd_data_o[i*XLEN +: XLEN] = '0;
        end else if (wr_en[HI] && (wa_i[HI*AW +: AW] == rd_addr_i[i*AW +: AW])) begin
          rd_data_o[i*XLEN +: XLEN] = wd_i[HI*XLEN +: XLEN];
        end else if (wr_en[LO] && (wa_i[LO*AW +: AW] == rd_addr_i[i*AW +: AW])) begin
          rd_data_o[i*XLEN +: XLEN] = wd_i[LO*XLEN +: XLEN];
        end else begin
          rd_data_o[i*XLEN +: XLEN] = mem[rd_addr_i[i*AW +: AW]];
        end
      end
    end
  end

  assign sb_set = ready && iss_valid_i && !((ZERO_REG != 0) && (iss_rd_i == '0));

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (sb_set),
    .set_addr_i (iss_rd_i),
    .clr_en_i   (wr_en),
    .clr_addr_i (wa_i),
    .flush_i    (ready && flush_i),
    .rd_addr_i  (rd_addr_i),
    .rd_pend_o  (sb_pend)
  );

  assign rd_pend_o = ready ? sb_pend : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-style bench for regfile_mp: a driver pushes model expectations, a monitor pops and compares.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   rdAddr;
  logic [NRD*XLEN-1:0] rdData;
  logic [NRD-1:0]      rdPend;
  logic [1:0]          we;
  logic [2*AW-1:0]     wa;
  logic [2*XLEN-1:0]   wd;
  logic                issValid;
  logic [AW-1:0]       issRd;
  logic                flush;
  logic                initBusy;

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr_i   (rdAddr),
    .rd_data_o   (rdData),
    .rd_pend_o   (rdPend),
    .we_i        (we),
    .wa_i        (wa),
    .wd_i        (wd),
    .iss_valid_i (issValid),
    .iss_rd_i    (issRd),
    .flush_i     (flush),
    .init_busy_o (initBusy)
  );

  typedef struct packed {
    logic          rstN;
    logic [1:0]    we;
    logic [AW-1:0] wa0;
    logic [AW-1:0] wa1;
    logic [31:0]   wd0;
    logic [31:0]   wd1;
    logic          issValid;
    logic [AW-1:0] issRd;
    logic          flush;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
  } stim_t;

  typedef struct packed {
    int          cyc;
    logic        busy;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        p0;
    logic        p1;
  } exp_t;

  exp_t expQ[$];
  int   errCount   = 0;
  int   checkCount = 0;
  int   cycle      = 0;

  // Reference model: architectural state only, updated once per clock edge.
  logic [31:0] mRegs [NREGS];
  bit          mPend [NREGS];
  bit          mBusy;
  int          mInitEdges;
  stim_t       lastStim;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.rstN = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] modelRead(input stim_t s, input logic [AW-1:0] a);
    if (a == 0) return 32'h0;
    if (s.we[1] && s.wa1 == a) return s.wd1;
    if (s.we[0] && s.wa0 == a) return s.wd0;
    return mRegs[a];
  endfunction

  function automatic logic modelPend(input stim_t s, input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if ((s.we[0] && s.wa0 == a) || (s.we[1] && s.wa1 == a)) return 1'b0;
    return mPend[a];
  endfunction

  function automatic exp_t modelOutputs(input stim_t s);
    exp_t e;
    e = '0;
    e.cyc = cycle;
    if (!s.rstN || mBusy) begin
      e.busy = 1'b1;
    end else begin
      e.d0 = modelRead(s, s.ra0);
      e.d1 = modelRead(s, s.ra1);
      e.p0 = modelPend(s, s.ra0);
      e.p1 = modelPend(s, s.ra1);
    end
    return e;
  endfunction

  task automatic modelEdge(input stim_t s);
    if (!s.rstN) begin
      mBusy = 1'b1;
      mInitEdges = 0;
      for (int r = 0; r < NREGS; r++) mPend[r] = 1'b0;
    end else if (mBusy) begin
      mInitEdges++;
      if (mInitEdges == NREGS) begin
        mBusy = 1'b0;
        for (int r = 0; r < NREGS; r++) mRegs[r] = 32'h0;
      end
    end else begin
      if (s.we[0] && s.wa0 != 0) mRegs[s.wa0] = s.wd0;
      if (s.we[1] && s.wa1 != 0) mRegs[s.wa1] = s.wd1;
      if (s.flush) begin
        for (int r = 0; r < NREGS; r++) mPend[r] = 1'b0;
      end else begin
        if (s.we[0]) mPend[s.wa0] = 1'b0;
        if (s.we[1]) mPend[s.wa1] = 1'b0;
        if (s.issValid && s.issRd != 0) mPend[s.issRd] = 1'b1;
      end
    end
  endtask

  // One cycle: retire the previous stimulus into the model at the edge, then drive and queue the expectation.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    modelEdge(lastStim);
    cycle++;
    #1;
    rst_n    = s.rstN;
    we       = s.we;
    wa       = {s.wa1, s.wa0};
    wd       = {s.wd1, s.wd0};
    issValid = s.issValid;
    issRd    = s.issRd;
    flush    = s.flush;
    rdAddr   = {s.ra1, s.ra0};
    lastStim = s;
    expQ.push_back(modelOutputs(s));
  endtask

  task automatic checkVal(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
    checkCount++;
    if (act !== req) begin
      errCount++;
      $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal("init_busy", e.cyc, 32'(initBusy), 32'(e.busy));
    checkVal("rd_data0", e.cyc, rdData[31:0], e.d0);
    checkVal("rd_data1", e.cyc, rdData[63:32], e.d1);
    checkVal("rd_pend0", e.cyc, 32'(rdPend[0]), 32'(e.p0));
    checkVal("rd_pend1", e.cyc, 32'(rdPend[1]), 32'(e.p1));
  endtask

  // Monitor: compares whenever an expectation is outstanding, away from the active edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  task automatic readAll();
    stim_t s;
    for (int i = 0; i < NREGS / 2; i++) begin
      s = idleStim();
      s.ra0 = AW'(i);
      s.ra1 = AW'(i + NREGS / 2);
      applyStimulus(s);
    end
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(idleStim());
  endtask

  task automatic resetPulse(input int n);
    stim_t s;
    s = idleStim();
    s.rstN = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0; we = '0; wa = '0; wd = '0;
    issValid = 1'b0; issRd = '0; flush = 1'b0; rdAddr = '0;
    lastStim = idleStim();
    lastStim.rstN = 1'b0;
    mBusy = 1'b1; mInitEdges = 0;
    for (int r = 0; r < NREGS; r++) begin
      mRegs[r] = 32'h0;
      mPend[r] = 1'b0;
    end

    // Power-on reset, then init with traffic that must be ignored.
    resetPulse(3);
    for (int i = 0; i < NREGS + 2; i++) begin
      s = idleStim();
      s.ra0 = 5;
      if (i == 4) begin
        s.we = 2'b01; s.wa0 = 5; s.wd0 = 32'hDEAD;
        s.issValid = 1'b1; s.issRd = 5;
      end
      applyStimulus(s);
    end
    readAll();

    // Bypass on port 0, then array read.
    s = idleStim(); s.we = 2'b01; s.wa0 = 7; s.wd0 = 32'h1234; s.ra0 = 7;
    applyStimulus(s);
    s = idleStim(); s.ra0 = 7;
    applyStimulus(s);

    // Dual write to the same address, then a write to register 0.
    s = idleStim(); s.we = 2'b11; s.wa0 = 3; s.wa1 = 3;
    s.wd0 = 32'hAAAA; s.wd1 = 32'hBBBB; s.ra0 = 3; s.ra1 = 3;
    applyStimulus(s);
    s = idleStim(); s.ra0 = 3;
    applyStimulus(s);
    s = idleStim(); s.we = 2'b10; s.wa1 = 0; s.wd1 = 32'hFFFF; s.ra0 = 0;
    applyStimulus(s);
    s = idleStim(); s.ra0 = 0;
    applyStimulus(s);

    // Scoreboard set, bypass clear, and set-beats-clear.
    s = idleStim(); s.issValid = 1'b1; s.issRd = 9; s.ra0 = 9;
    applyStimulus(s);
    s = idleStim(); s.ra0 = 9;
    applyStimulus(s);
    s = idleStim(); s.we = 2'b01; s.wa0 = 9; s.wd0 = 32'h99; s.ra0 = 9;
    applyStimulus(s);
    s = idleStim(); s.ra0 = 9;
    applyStimulus(s);
    s = idleStim(); s.issValid = 1'b1; s.issRd = 9;
    s.we = 2'b10; s.wa1 = 9; s.wd1 = 32'h77; s.ra1 = 9;
    applyStimulus(s);
    s = idleStim(); s.ra0 = 9; s.ra1 = 9;
    applyStimulus(s);

    // Flush overrides a same-cycle set.
    for (int r = 4; r <= 12; r += 4) begin
      s = idleStim(); s.issValid = 1'b1; s.issRd = AW'(r);
      applyStimulus(s);
    end
    s = idleStim(); s.ra0 = 4; s.ra1 = 8;
    applyStimulus(s);
    s = idleStim(); s.flush = 1'b1; s.issValid = 1'b1; s.issRd = 4;
    applyStimulus(s);
    s = idleStim(); s.ra0 = 4; s.ra1 = 8;
    applyStimulus(s);
    s = idleStim(); s.ra0 = 12; s.ra1 = 9;
    applyStimulus(s);

    // Randomized traffic over a narrow address range to force collisions.
    for (int i = 0; i < 300; i++) begin
      s = idleStim();
      s.we       = 2'($urandom_range(0, 3));
      s.wa0      = AW'($urandom_range(0, 11));
      s.wa1      = AW'($urandom_range(0, 11));
      s.wd0      = $urandom;
      s.wd1      = $urandom;
      s.issValid = 1'($urandom_range(0, 1));
      s.issRd    = AW'($urandom_range(0, 11));
      s.flush    = ($urandom_range(0, 15) == 0);
      s.ra0      = AW'($urandom_range(0, 11));
      s.ra1      = AW'($urandom_range(0, 11));
      applyStimulus(s);
    end

    // Reset in the middle of init at count 10.
    resetPulse(1);
    runIdle(10);
    resetPulse(1);
    runIdle(NREGS + 1);
    readAll();

    // Reset while ready, after writes and pending producers.
    for (int i = 1; i < 6; i++) begin
      s = idleStim(); s.we = 2'b01; s.wa0 = AW'(i * 3); s.wd0 = $urandom;
      s.issValid = 1'b1; s.issRd = AW'(i * 5);
      applyStimulus(s);
    end
    resetPulse(2);
    runIdle(NREGS + 1);
    readAll();

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    if (expQ.size() != 0) begin
      errCount++;
      $display("[TB] FAIL queue_drain actual=%0d required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
